// File: rtl/operand_fifo.sv
// Operand-pair FIFO feeding the adder datapath.
// First-word fall-through circular buffer with flush.
module operand_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_a,
    output logic [WIDTH-1:0]         out_b,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      cnt;
    logic               push;
    logic               pop;

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = cnt;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign {out_a, out_b} = mem[rd_ptr];

    // Data storage carries no reset; stale contents are hidden by out_valid.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_operand_fifo.sv
// Randomized self-checking bench for operand_fifo.
// A queue-based reference model predicts all outputs.
module tb_operand_fifo;

    localparam int W = 4;
    localparam int D = 4;
    localparam int CW = $clog2(D) + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_a;
    logic [W-1:0]  out_b;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic [W:0]    c;

    pair_t q[$];
    int    n_checks;
    int    n_errors;
    int    n_pushed;

    operand_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Downstream adder
    assign c = out_a + out_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_state();
        int sz;
        sz = q.size();
        check("count", int'(count), sz);
        check("empty", int'(empty), int'(sz == 0));
        check("full", int'(full), int'(sz == D));
        check("in_ready", int'(in_ready), int'(sz != D));
        check("out_valid", int'(out_valid), int'(sz != 0));
        if (sz != 0) begin
            check("out_a", int'(out_a), int'(q[0].a));
            check("out_b", int'(out_b), int'(q[0].b));
        end
    endtask

    task automatic cycle(input logic r, input logic f, input logic iv,
                         input int a, input int b, input logic ordy);
        bit    do_push;
        bit    do_pop;
        pair_t p;
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_a      = W'(a);
        in_b      = W'(b);
        out_ready = ordy;
        do_pop  = ordy && (q.size() != 0);
        do_push = iv && (q.size() != D);
        if (do_pop && !r) begin
            check("adder_c", int'(c), int'(q[0].a) + int'(q[0].b));
        end
        @(posedge clk);
        #1;
        if (r || f) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                p.a = W'(a);
                p.b = W'(b);
                q.push_back(p);
                n_pushed++;
            end
        end
        compare_state();
    endtask

    initial begin
        int budget;
        n_checks  = 0;
        n_errors  = 0;
        n_pushed  = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        cycle(1, 0, 0, 0, 0, 0);
        check("rst_empty", int'(empty), 1);
        check("rst_in_ready", int'(in_ready), 1);

        cycle(0, 0, 1, 3, 5, 0);
        check("single_a", int'(out_a), 3);
        check("single_b", int'(out_b), 5);
        cycle(0, 0, 0, 0, 0, 1);

        for (int i = 1; i <= 4; i++) cycle(0, 0, 1, i, i, 0);
        check("fill_full", int'(full), 1);
        cycle(0, 0, 1, 5, 5, 0);
        check("fill_count", int'(count), 4);

        cycle(0, 0, 0, 0, 0, 1);
        check("pop_full_ready", int'(in_ready), 1);
        check("pop_full_head", int'(out_a), 2);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1);

        cycle(0, 0, 1, 8, 8, 0);
        cycle(0, 0, 1, 9, 9, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, i, 15 - i, 1);
        check("wrap_count", int'(count), 2);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 10 + i, i, 0);
        cycle(0, 1, 1, 7, 7, 0);
        check("flush_empty", int'(empty), 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 4 + i, 2 * i, 0);
        cycle(1, 0, 1, 7, 7, 1);
        check("rst_mid_empty", int'(empty), 1);
        cycle(0, 0, 1, 6, 9, 0);
        cycle(0, 0, 0, 0, 0, 1);

        n_pushed = 0;
        budget   = 0;
        while (n_pushed < 100 && budget < 2000) begin
            cycle(0, 0, ($urandom % 4) != 0, int'($urandom % 16),
                  int'($urandom % 16), $urandom % 2);
            budget++;
        end
        check("rand_pushes", n_pushed, 100);
        budget = 0;
        while (q.size() != 0 && budget < 20) begin
            cycle(0, 0, 0, 0, 0, 1);
            budget++;
        end
        check("drain_empty", int'(empty), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
